// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
// Sequences the 5-stage MIPS pipeline around load-use and control hazards.
// It drives the PC and IF/ID load enables and the IF/ID and ID/EX flushes.
// The outputs are Mealy outputs decoded from the registered state, the down-counter
// and the current hazard inputs, so they act in the same cycle.
// Optional feature: define HAZARD_PERF_COUNTERS_EN to build saturating stall and
// flush cycle counters. When it is undefined, both counter ports read 0.
`timescale 1ns/1ps

module pipeline_hazard_controller #(
    parameter int LOAD_USE_STALL_CYCLES = 1,
    parameter int BRANCH_FLUSH_CYCLES   = 1,
    parameter int CNT_WIDTH             = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           id_rs_i,
    input  logic [4:0]           id_rt_i,
    input  logic                 id_uses_rt_i,
    input  logic [4:0]           ex_rt_i,
    input  logic                 ex_mem_read_i,
    input  logic                 ex_branch_taken_i,
    input  logic                 id_jump_i,
    input  logic                 id_jr_i,
    output logic                 pc_write_o,
    output logic                 if_id_write_o,
    output logic                 if_id_flush_o,
    output logic                 id_ex_flush_o,
    output logic [1:0]           state_o,
    output logic [CNT_WIDTH-1:0] stall_count_o,
    output logic [CNT_WIDTH-1:0] flush_count_o
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        STALL   = 2'b01,
        FLUSH   = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    // The value loaded into cnt is the number of cycles that remain after the triggering cycle.
    localparam logic [2:0] LU_RELOAD = 3'(LOAD_USE_STALL_CYCLES - 1);
    localparam logic [2:0] BR_RELOAD = 3'(BRANCH_FLUSH_CYCLES - 1);

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       load_use;

    // Load-use hazard: a load in EX writes a register that the instruction in ID reads. $0 is excluded.
    assign load_use = ex_mem_read_i && (ex_rt_i != 5'd0) &&
                      ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));

    // Next state, next count and the Mealy outputs. Priority is branch > jump/jr > load-use > state.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        pc_write_o    = 1'b1;
        if_id_write_o = 1'b1;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        state_nxt     = RUN;
        cnt_nxt       = 3'd0;

        if (ex_branch_taken_i) begin
            // A taken branch discards both younger instructions and restarts any flush sequence.
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            if (BRANCH_FLUSH_CYCLES > 1) begin
                state_nxt = FLUSH;
                cnt_nxt   = BR_RELOAD;
            end
        end else begin
            case (state)
                RUN: begin
                    if (id_jump_i || id_jr_i) begin
                        // The jump target is already known in ID, so only the fetched slot is squashed.
                        if_id_flush_o = 1'b1;
                    end else if (load_use) begin
                        pc_write_o    = 1'b0;
                        if_id_write_o = 1'b0;
                        id_ex_flush_o = 1'b1;
                        if (LOAD_USE_STALL_CYCLES > 1) begin
                            state_nxt = STALL;
                            cnt_nxt   = LU_RELOAD;
                        end
                    end
                end
                STALL: begin
                    // ID is frozen here, so a jump in ID is presented again after the stall ends.
                    pc_write_o    = 1'b0;
                    if_id_write_o = 1'b0;
                    id_ex_flush_o = 1'b1;
                    if (cnt != 3'd1) begin
                        state_nxt = STALL;
                        cnt_nxt   = cnt - 3'd1;
                    end
                end
                FLUSH: begin
                    if_id_flush_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                    if (cnt != 3'd1) begin
                        state_nxt = FLUSH;
                        cnt_nxt   = cnt - 3'd1;
                    end
                end
                default: begin
                    // The unused encoding behaves as idle RUN and returns to RUN next cycle.
                end
            endcase
        end
    end

    // State and down-counter registers. Reset drops any pending stall or flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign state_o = state;

`ifdef HAZARD_PERF_COUNTERS_EN
    // Saturating counters of stall cycles (PC held) and flush cycles (IF/ID squashed).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_o <= '0;
            flush_count_o <= '0;
        end else begin
            if (!pc_write_o && (stall_count_o != '1))
                stall_count_o <= stall_count_o + 1'b1;
            if (if_id_flush_o && (flush_count_o != '1))
                flush_count_o <= flush_count_o + 1'b1;
        end
    end
`else
    assign stall_count_o = '0;
    assign flush_count_o = '0;
`endif

endmodule
